// File: rtl/wifi_cmd_scheduler.sv
// Command FIFO and sequencer feeding the WiFi UART sender: drains (comando, datos)
// pairs one at a time using start/bussy as a handshake, with a transfer timeout.
//
// state | meaning
// IDLE  | waiting for a queued entry and a free sender; pops on exit
// LOAD  | bytes presented, start held low for one cycle
// REQ   | start high until the sender reports bussy
// RUN   | sender busy, waiting for bussy to fall
module wifi_cmd_scheduler #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        cmd_in,
    input  logic [7:0]        data_in,
    input  logic              flush,
    input  logic              clr_err,
    input  logic              bussy,
    output logic [7:0]        comando,
    output logic [7:0]        datos,
    output logic              start,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              idle,
    output logic              err_timeout,
    output logic              err_overflow
);
    typedef enum logic [1:0] {IDLE, LOAD, REQ, RUN} state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [15:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count, count_nxt;
    logic [15:0]         tmo_cnt;
    logic                pop, push_ok, push_drop, in_xfer, tmo_set;

    assign in_xfer   = (state == REQ) || (state == RUN);
    assign tmo_set   = in_xfer && (tmo_cnt == TMO_LAST);
    assign pop       = (state == IDLE) && !empty && !bussy && !flush;
    // A push into a full FIFO only fits when the head leaves on the same edge.
    assign push_ok   = push && !flush && (!full || pop);
    assign push_drop = push && !flush && full && !pop;

    assign level = count;
    assign idle  = (state == IDLE) && empty;

    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push_ok && !pop)
            count_nxt = count + (ADDR_W+1)'(1);
        else if (pop && !push_ok)
            count_nxt = count - (ADDR_W+1)'(1);
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        case (state)
            IDLE: if (pop) state_nxt = LOAD;
            LOAD: state_nxt = REQ;
            REQ: begin
                start = 1'b1;
                if (tmo_set)
                    state_nxt = IDLE;
                else if (bussy)
                    state_nxt = RUN;
            end
            RUN: if (tmo_set || !bussy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {cmd_in, data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            tmo_cnt      <= '0;
            comando      <= '0;
            datos        <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (pop) begin
                comando <= mem[rd_ptr][15:8];
                datos   <= mem[rd_ptr][7:0];
            end
            tmo_cnt      <= in_xfer ? tmo_cnt + 16'd1 : 16'd0;
            // Set beats clear when both happen on the same edge.
            err_timeout  <= tmo_set   | (err_timeout  & ~clr_err);
            err_overflow <= push_drop | (err_overflow & ~clr_err);
        end
    end
endmodule
